// File: rtl/if_fetch_unit.sv
// if_fetch_unit: pipelined instruction-fetch front end.
// Owns the PC, issues one word read per cycle to a synchronous instruction
// memory (one-cycle latency), buffers {pc, instr} pairs in a small FIFO and
// presents them to decode over a valid/ready handshake. Redirects flush the
// stage and restart fetch at the new PC.
// Optional feature: define IF_BYPASS_EN to forward a response straight to
// decode when the FIFO is empty (fetch-to-decode latency drops to 1 cycle).
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 10,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so count + inflight never overflows before the compare.
    localparam int CRD_W = CNT_W + 1;
    localparam logic [CRD_W-1:0] DEPTH_C = CRD_W'(DEPTH);

    // Control state (reset)
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Data state (no reset; outputs are gated by id_valid)
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0]  mem_pc_q    [DEPTH];
    logic [XLEN-1:0]  mem_instr_q [DEPTH];

    logic             resp;
    logic             fifo_nonempty;
    logic             bypass;
    logic             pop;
    logic             pop_fifo;
    logic             push;
    logic             issue;
    logic [CRD_W-1:0] credit_used;

    // The two low bits of the redirect target are architecturally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake, credit check and output selection.
    always_comb begin
        resp          = inflight_q && !drop_q;
        fifo_nonempty = (count_q != '0);
`ifdef IF_BYPASS_EN
        bypass        = resp && !fifo_nonempty;
`else
        bypass        = 1'b0;
`endif
        id_valid      = fifo_nonempty || bypass;
        pop           = id_valid && id_ready;
        // A bypassed response consumed by decode never enters the FIFO.
        pop_fifo      = pop && fifo_nonempty;
        push          = resp && !(bypass && id_ready);
        // Credit counts buffered entries plus the response still on its way,
        // minus the slot freed by this cycle's pop.
        credit_used   = CRD_W'(count_q) + CRD_W'(inflight_q) - CRD_W'(pop);
        issue         = rst_n && !redirect_valid && (credit_used < DEPTH_C);
        imem_en       = issue;
        imem_addr     = pc_q[ADDR_W+1:2];
        id_pc         = '0;
        id_instr      = '0;
        if (bypass) begin
            id_pc    = inflight_pc_q;
            id_instr = imem_rdata;
        end else if (fifo_nonempty) begin
            id_pc    = mem_pc_q[rd_ptr_q];
            id_instr = mem_instr_q[rd_ptr_q];
        end
    end

    // Next-state: redirect flushes everything and takes priority over issue.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        drop_d        = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d   = inflight_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + XLEN'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_fifo) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Datapath registers: in-flight PC and FIFO storage.
    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
        if (push && !redirect_valid) begin
            mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
